// File: rtl/gf8_mul_scheduler_if.sv
// rtl/gf8_mul_scheduler_if.sv - requester request/response bundle for the shared GF(2^3) multiplier scheduler
interface gf8_mul_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_op;
    logic [3*NUM_REQ-1:0] req_a;
    logic [3*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [2:0]           rsp_y;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, rsp_valid, rsp_y
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, rsp_valid, rsp_y
    );
endinterface

// File: rtl/gf8_mul_scheduler.sv
// rtl/gf8_mul_scheduler.sv - round-robin scheduler sharing one GF(2^3) multiplier for multiply and A^E
module gf8_mul_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                n_rst,
    gf8_mul_scheduler_if.slave  bus,
    output logic [2:0]          mul_a,
    output logic [2:0]          mul_b,
    input  logic [2:0]          mul_y,
    output logic                busy,
    output logic [IDW-1:0]      grant_id
);

    typedef enum logic [2:0] {IDLE, MUL, SQ, PM, DONE} state_t;

    state_t         state, state_d;
    logic [IDW-1:0] rr_ptr;
    logic [2:0]     a_q, b_q, acc, acc_d;
    logic [1:0]     bit_q, bit_d;

    logic           found, found_hi;
    logic [IDW-1:0] g, g_hi, g_lo;
    logic [2:0]     a_sel, b_sel;
    logic           op_sel;
    logic           accept;

    // First valid above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        found_hi = 1'b0;
        g_hi     = '0;
        g_lo     = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (bus.req_valid[j]) begin
                g_lo = IDW'(j);
                if (IDW'(j) > rr_ptr) begin
                    g_hi     = IDW'(j);
                    found_hi = 1'b1;
                end
            end
        end
        g     = found_hi ? g_hi : g_lo;
        found = |bus.req_valid;
    end

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (g == IDW'(j)) begin
                a_sel  = bus.req_a[3*j +: 3];
                b_sel  = bus.req_b[3*j +: 3];
                op_sel = bus.req_op[j];
            end
        end
    end

    assign accept = (state == IDLE) && found;
    assign busy   = (state != IDLE);

    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            bus.req_ready[j] = accept && (g == IDW'(j));
            bus.rsp_valid[j] = (state == DONE) && (grant_id == IDW'(j));
        end
        bus.rsp_y = (state == DONE) ? acc : 3'd0;
    end

    always_comb begin
        state_d = state;
        acc_d   = acc;
        bit_d   = bit_q;
        mul_a   = 3'd0;
        mul_b   = 3'd0;
        case (state)
            IDLE: begin
                if (found) begin
                    if (op_sel) begin
                        acc_d   = 3'd1;
                        bit_d   = 2'd2;
                        state_d = SQ;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                mul_a   = a_q;
                mul_b   = b_q;
                acc_d   = mul_y;
                state_d = DONE;
            end
            SQ: begin
                mul_a = acc;
                mul_b = acc;
                acc_d = mul_y;
                if (b_q[bit_q]) begin
                    state_d = PM;
                end else if (bit_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    bit_d = bit_q - 2'd1;
                end
            end
            PM: begin
                mul_a = acc;
                mul_b = a_q;
                acc_d = mul_y;
                if (bit_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    bit_d   = bit_q - 2'd1;
                    state_d = SQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            rr_ptr   <= IDW'(NUM_REQ - 1);
            grant_id <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            bit_q    <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            bit_q <= bit_d;
            if (accept) begin
                rr_ptr   <= g;
                grant_id <= g;
                a_q      <= a_sel;
                b_q      <= b_sel;
            end
        end
    end

endmodule

// File: tb/tb_gf8_mul_scheduler.sv
// tb/tb_gf8_mul_scheduler.sv - scoreboard bench for gf8_mul_scheduler
module tb_gf8_mul_scheduler;
    localparam int N = 4;

    logic       clk;
    logic       n_rst;
    logic [2:0] mul_a, mul_b, mul_y;
    logic       busy;
    logic [1:0] grant_id;

    gf8_mul_scheduler_if #(.NUM_REQ(N)) bus ();

    gf8_mul_scheduler #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .bus      (bus),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_y    (mul_y),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] p, aa;
        p  = 3'd0;
        aa = a;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[2] ? ({aa[1:0], 1'b0} ^ 3'b101) : {aa[1:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [2:0] gf_pow(input logic [2:0] a, input logic [2:0] e);
        logic [2:0] r;
        r = 3'd1;
        for (int i = 0; i < int'(e); i++) r = gf_mul(r, a);
        return r;
    endfunction

    // External shared multiplier
    assign mul_y = gf_mul(mul_a, mul_b);

    typedef struct {
        int         id;
        logic [2:0] y;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         gq[$];
    int         gcyc[$];
    int         acc_cyc[N];
    int         rsp_cyc[N];
    int         cyc;
    int         vectors;
    int         miscompares;
    int         ready1_cnt;
    logic [N-1:0] last_acc;
    logic       snap_busy;
    logic [2:0] snap_mul_a, snap_mul_b;

    task automatic issue(input int id, input logic op, input logic [2:0] a, input logic [2:0] b,
                         input bit push);
        exp_t e;
        bus.req_op[id]         = op;
        bus.req_a[id*3 +: 3]   = a;
        bus.req_b[id*3 +: 3]   = b;
        bus.req_valid[id]      = 1'b1;
        if (push) begin
            e.id  = id;
            e.y   = op ? gf_pow(a, b) : gf_mul(a, b);
            e.lat = op ? 4 + $countones(b) : 2;
            sb.push_back(e);
        end
    endtask

    task automatic step();
        logic [N-1:0] a_acc;
        int k;
        @(negedge clk);
        cyc++;
        snap_busy  = busy;
        snap_mul_a = mul_a;
        snap_mul_b = mul_b;
        a_acc      = bus.req_ready & bus.req_valid;
        last_acc   = a_acc;
        if (bus.req_ready[1]) ready1_cnt++;
        vectors++;
        if ((busy && bus.req_ready !== '0) || !$onehot0(bus.req_ready)) begin
            miscompares++;
            $display("FAIL ready_gating cyc=%0d got req_ready=%b busy=%b", cyc, bus.req_ready, busy);
        end
        vectors++;
        if (!$onehot0(bus.rsp_valid) || (bus.rsp_valid == '0 && bus.rsp_y !== 3'd0)) begin
            miscompares++;
            $display("FAIL rsp_idle cyc=%0d got rsp_valid=%b rsp_y=%0d want onehot0 and y=0 when idle",
                     cyc, bus.rsp_valid, bus.rsp_y);
        end
        for (int i = 0; i < N; i++) begin
            if (a_acc[i]) begin
                acc_cyc[i] = cyc;
                gq.push_back(i);
                gcyc.push_back(cyc);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.rsp_valid[i] === 1'b1) begin
                rsp_cyc[i] = cyc;
                k = -1;
                for (int s = sb.size() - 1; s >= 0; s--) if (sb[s].id == i) k = s;
                vectors++;
                if (k < 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rsp cyc=%0d got rsp_valid[%0d] y=%0d want none", cyc, i, bus.rsp_y);
                end else begin
                    vectors++;
                    if (bus.rsp_y !== sb[k].y) begin
                        miscompares++;
                        $display("FAIL rsp_y req%0d got %0d want %0d", i, bus.rsp_y, sb[k].y);
                    end
                    vectors++;
                    if (cyc - acc_cyc[i] != sb[k].lat) begin
                        miscompares++;
                        $display("FAIL latency req%0d got %0d want %0d", i, cyc - acc_cyc[i], sb[k].lat);
                    end
                    vectors++;
                    if (grant_id !== 2'(i)) begin
                        miscompares++;
                        $display("FAIL grant_id got %0d want %0d", grant_id, i);
                    end
                    sb.delete(k);
                end
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~a_acc;
    endtask

    task automatic wait_accept(input int id, input int budget);
        int n;
        n = 0;
        last_acc = '0;
        while (!last_acc[id] && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (!last_acc[id]) begin
            miscompares++;
            $display("FAIL accept_timeout req%0d got no req_ready within %0d cycles", id, budget);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || snap_busy || bus.req_valid != '0) && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL drain_timeout got %0d outstanding, busy=%b want 0 within %0d cycles",
                     sb.size(), snap_busy, budget);
            sb.delete();
            bus.req_valid = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || bus.req_ready !== '0 || bus.rsp_valid !== '0 ||
            bus.rsp_y !== 3'd0 || mul_a !== 3'd0 || mul_b !== 3'd0) begin
            miscompares++;
            $display("FAIL %s got busy=%b gid=%0d rdy=%b rv=%b y=%0d ma=%0d mb=%0d want all 0",
                     tag, busy, grant_id, bus.req_ready, bus.rsp_valid, bus.rsp_y, mul_a, mul_b);
        end
    endtask

    task automatic test_reset();
        n_rst         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        step();
        step();
        check_reset_outputs("reset_state");
        n_rst = 1'b1;
        step();
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_multiply();
        logic [2:0] a, b;
        issue(0, 1'b0, 3'd3, 3'd5, 1'b1);
        wait_accept(0, 10);
        step();
        vectors++;
        if (snap_mul_a !== 3'd3 || snap_mul_b !== 3'd5) begin
            miscompares++;
            $display("FAIL mul_operands got a=%0d b=%0d want a=3 b=5", snap_mul_a, snap_mul_b);
        end
        wait_drain(20);
        for (int k = 0; k < 6; k++) begin
            a = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            issue(k % N, 1'b0, a, b, 1'b1);
            wait_drain(20);
        end
    endtask

    task automatic test_power();
        logic [2:0] exps [3];
        exps = '{3'd3, 3'd4, 3'd7};
        for (int k = 0; k < 3; k++) begin
            issue(1, 1'b1, 3'd2, exps[k], 1'b1);
            wait_drain(20);
        end
    endtask

    task automatic test_power_bounds();
        logic [2:0] pa [3];
        logic [2:0] pe [3];
        pa = '{3'd0, 3'd0, 3'd3};
        pe = '{3'd0, 3'd5, 3'd0};
        for (int k = 0; k < 3; k++) begin
            issue(2, 1'b1, pa[k], pe[k], 1'b1);
            wait_drain(20);
        end
        for (int a = 1; a < 8; a++) begin
            issue(3, 1'b1, 3'(a), 3'd7, 1'b1);
            wait_drain(20);
        end
    endtask

    task automatic test_round_robin();
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        gq.delete();
        gcyc.delete();
        for (int i = 0; i < N; i++) issue(i, 1'b0, 3'(i + 1), 3'(7 - i), 1'b1);
        wait_drain(60);
        vectors++;
        if (gq.size() != 4) begin
            miscompares++;
            $display("FAIL rr_count got %0d grants want 4", gq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (gq[k] != k) begin
                    miscompares++;
                    $display("FAIL rr_order slot%0d got %0d want %0d", k, gq[k], k);
                end
                if (k > 0) begin
                    vectors++;
                    if (gcyc[k] - gcyc[k-1] != 3) begin
                        miscompares++;
                        $display("FAIL rr_spacing slot%0d got %0d want 3", k, gcyc[k] - gcyc[k-1]);
                    end
                end
            end
        end
        gq.delete();
        issue(0, 1'b0, 3'd6, 3'd3, 1'b1);
        issue(2, 1'b0, 3'd7, 3'd7, 1'b1);
        wait_drain(30);
        vectors++;
        if (gq.size() != 2 || gq[0] != 0 || gq[1] != 2) begin
            miscompares++;
            $display("FAIL rr_reassert got %0d grants first=%0d want 2 grants order 0,2",
                     gq.size(), (gq.size() > 0) ? gq[0] : -1);
        end
    endtask

    task automatic test_reset_mid_op();
        issue(2, 1'b1, 3'd5, 3'd7, 1'b0);
        wait_accept(2, 10);
        step();
        step();
        vectors++;
        if (snap_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_mid_power got %b want 1", snap_busy);
        end
        n_rst = 1'b0;
        #1;
        check_reset_outputs("async_abort");
        step();
        n_rst = 1'b1;
        for (int k = 0; k < 10; k++) step();
        gq.delete();
        issue(3, 1'b0, 3'd4, 3'd4, 1'b1);
        issue(0, 1'b0, 3'd5, 3'd6, 1'b1);
        wait_drain(30);
        vectors++;
        if (gq.size() != 2 || gq[0] != 0 || gq[1] != 3) begin
            miscompares++;
            $display("FAIL post_reset_order got %0d grants first=%0d want order 0,3",
                     gq.size(), (gq.size() > 0) ? gq[0] : -1);
        end
    endtask

    task automatic test_busy_drop();
        gq.delete();
        ready1_cnt = 0;
        issue(0, 1'b1, 3'd3, 3'd7, 1'b1);
        wait_accept(0, 10);
        issue(3, 1'b0, 3'd6, 3'd6, 1'b1);
        issue(1, 1'b0, 3'd2, 3'd2, 1'b0);
        step();
        step();
        step();
        bus.req_valid[1] = 1'b0;
        wait_drain(30);
        vectors++;
        if (ready1_cnt != 0) begin
            miscompares++;
            $display("FAIL dropped_req_ready got %0d strobes want 0", ready1_cnt);
        end
        vectors++;
        if (gq.size() != 2 || gq[0] != 0 || gq[1] != 3) begin
            miscompares++;
            $display("FAIL busy_grants got %0d grants want order 0,3", gq.size());
        end
        vectors++;
        if (acc_cyc[3] != rsp_cyc[0] + 1) begin
            miscompares++;
            $display("FAIL next_idle_accept got cyc %0d want %0d", acc_cyc[3], rsp_cyc[0] + 1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        ready1_cnt  = 0;
        snap_busy   = 1'b0;
        last_acc    = '0;
        for (int i = 0; i < N; i++) begin
            acc_cyc[i] = 0;
            rsp_cyc[i] = 0;
        end
        test_reset();
        test_multiply();
        test_power();
        test_power_bounds();
        test_round_robin();
        test_reset_mid_op();
        test_busy_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
